// File: rtl/shared_mem_arbiter_pkg.sv
// Shared definitions for the shared-memory arbiter slice: default geometry and pointer helpers.
package shared_mem_arbiter_pkg;

    localparam int unsigned DEF_NUM_CORES = 4;
    localparam int unsigned DEF_ADDR_W    = 8;
    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_LOCK_MAX  = 8;

    // Round-robin successor of a core index, wrapping n-1 -> 0.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/shared_mem_arbiter_if.sv
// Core-side bus of the shared-memory arbiter: requests in, grants and read data out.
interface shared_mem_arbiter_if #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8
);
    logic [NUM_CORES-1:0]        req;
    logic [NUM_CORES-1:0]        we;
    logic [NUM_CORES*ADDR_W-1:0] addr;
    logic [NUM_CORES*DATA_W-1:0] wdata;
    logic [NUM_CORES-1:0]        lock;
    logic [NUM_CORES-1:0]        gnt;
    logic [NUM_CORES-1:0]        rvalid;
    logic [DATA_W-1:0]           rdata;

    modport master (output req, we, addr, wdata, lock, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, lock, output gnt, rvalid, rdata);
endinterface

// File: rtl/shared_mem_arbiter_rr_priority_pick.sv
// Round-robin pick: first set request at or after the pointer, wrapping to 0.
module rr_priority_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_onehot,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_valid
);
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            logic [PTR_W:0]   sum;
            logic [PTR_W-1:0] k;
            sum = {1'b0, i_ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(N)) sum = sum - (PTR_W+1)'(N);
            k = sum[PTR_W-1:0];
            if (!o_valid && i_req[k]) begin
                o_valid     = 1'b1;
                o_idx       = k;
                o_onehot[k] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter giving NUM_CORES cores access to one single-port synchronous memory.
// Optional locked bursts are compiled in with `define SHARED_MEM_ARB_LOCK_EN.
module shared_mem_arbiter
    import shared_mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CORES = DEF_NUM_CORES,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned LOCK_MAX  = DEF_LOCK_MAX
) (
    input  logic                 clk,
    input  logic                 reset,
    shared_mem_arbiter_if.slave  bus,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata
);
    localparam int unsigned PTR_W = $clog2(NUM_CORES);

    logic [NUM_CORES-1:0] r_gnt;
    logic [NUM_CORES-1:0] r_rd_pend;
    logic                 r_mem_en;
    logic                 r_mem_we;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [DATA_W-1:0]    r_mem_wdata;
    logic [PTR_W-1:0]     r_rr_ptr;

    logic [NUM_CORES-1:0] w_elig;
    logic [NUM_CORES-1:0] w_win;
    logic [PTR_W-1:0]     w_idx;
    logic                 w_valid;

`ifdef SHARED_MEM_ARB_LOCK_EN
    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    logic             r_own_vld;
    logic [PTR_W-1:0] r_owner;
    logic [CNT_W-1:0] r_lock_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    // A live owner bypasses the grant mask so it can win back-to-back.
    always_comb begin
        w_elig = bus.req & ~r_gnt;
        if (r_own_vld && bus.lock[r_owner] && bus.req[r_owner]) begin
            w_elig          = '0;
            w_elig[r_owner] = 1'b1;
        end
    end

    assign w_cnt_next = (r_own_vld && r_owner == w_idx) ? r_lock_cnt + 1'b1 : CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_own_vld  <= 1'b0;
            r_owner    <= '0;
            r_lock_cnt <= '0;
        end else if (w_valid && bus.lock[w_idx]) begin
            if (32'(w_cnt_next) >= LOCK_MAX) begin
                r_own_vld  <= 1'b0;
                r_lock_cnt <= '0;
            end else begin
                r_own_vld  <= 1'b1;
                r_owner    <= w_idx;
                r_lock_cnt <= w_cnt_next;
            end
        end else begin
            r_own_vld  <= 1'b0;
            r_lock_cnt <= '0;
        end
    end
`else
    assign w_elig = bus.req & ~r_gnt;
`endif

    rr_priority_pick #(
        .N     (NUM_CORES),
        .PTR_W (PTR_W)
    ) u_pick (
        .i_req    (w_elig),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_win),
        .o_idx    (w_idx),
        .o_valid  (w_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt       <= '0;
            r_rd_pend   <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_gnt     <= w_win;
            r_mem_en  <= w_valid;
            // Memory answers one cycle after the access, so flag the reader now.
            r_rd_pend <= (r_mem_en && !r_mem_we) ? r_gnt : '0;
            if (w_valid) begin
                r_mem_we    <= bus.we[w_idx];
                r_mem_addr  <= bus.addr[w_idx*ADDR_W +: ADDR_W];
                r_mem_wdata <= bus.wdata[w_idx*DATA_W +: DATA_W];
                r_rr_ptr    <= PTR_W'(wrap_inc(32'(w_idx), NUM_CORES));
            end else begin
                r_mem_we <= 1'b0;
            end
        end
    end

    assign bus.gnt    = r_gnt;
    assign bus.rvalid = r_rd_pend;
    assign bus.rdata  = (|r_rd_pend) ? mem_rdata : '0;

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Self-checking bench for shared_mem_arbiter; read data scored through an expectation queue.
module tb_shared_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] onehot;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    shared_mem_arbiter_if #(.NUM_CORES(4), .ADDR_W(8), .DATA_W(8)) bus ();

    shared_mem_arbiter #(
        .NUM_CORES (4),
        .ADDR_W    (8),
        .DATA_W    (8),
        .LOCK_MAX  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [7:0] a);
        return a ^ 8'hA5;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
        mem[8'h10] <= 8'h5A;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    // Every rvalid must match the oldest outstanding expected read.
    always @(negedge clk) begin
        if (bus.rvalid !== 4'b0000) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL rvalid_unexpected: got rvalid=%b rdata=%h, required no rvalid", bus.rvalid, bus.rdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.rvalid !== e.onehot || bus.rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL rvalid_data: got rvalid=%b rdata=%h, required rvalid=%b rdata=%h",
                             bus.rvalid, bus.rdata, e.onehot, e.data);
                end
            end
        end
    end

    task automatic set_core(input int c, input logic r, input logic w, input logic [7:0] a,
                            input logic [7:0] d, input logic l);
        bus.req[c]          = r;
        bus.we[c]           = w;
        bus.addr[c*8 +: 8]  = a;
        bus.wdata[c*8 +: 8] = d;
        bus.lock[c]         = l;
    endtask

    task automatic clear_all();
        bus.req = '0; bus.we = '0; bus.lock = '0; bus.addr = '0; bus.wdata = '0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_all();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.gnt !== 4'b0)    begin n_fail++; $display("FAIL reset_gnt: got %b, required 0000", bus.gnt); end
        n_checks++; if (bus.rvalid !== 4'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b, required 0000", bus.rvalid); end
        n_checks++; if (bus.rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h, required 00", bus.rdata); end
        n_checks++; if (mem_en !== 1'b0)     begin n_fail++; $display("FAIL reset_mem_en: got %b, required 0", mem_en); end
        n_checks++; if (mem_we !== 1'b0)     begin n_fail++; $display("FAIL reset_mem_we: got %b, required 0", mem_we); end
        n_checks++; if (mem_addr !== 8'h00)  begin n_fail++; $display("FAIL reset_mem_addr: got %h, required 00", mem_addr); end
        n_checks++; if (mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_mem_wdata: got %h, required 00", mem_wdata); end
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        set_core(2, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
        sb.push_back('{4'b0100, 8'h5A});
        @(negedge clk);
        n_checks++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt: got %b, required 0100", bus.gnt); end
        n_checks++; if (mem_en !== 1'b1)     begin n_fail++; $display("FAIL single_mem_en: got %b, required 1", mem_en); end
        n_checks++; if (mem_we !== 1'b0)     begin n_fail++; $display("FAIL single_mem_we: got %b, required 0", mem_we); end
        n_checks++; if (mem_addr !== 8'h10)  begin n_fail++; $display("FAIL single_mem_addr: got %h, required 10", mem_addr); end
        set_core(2, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0);
        @(negedge clk);
        n_checks++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL single_no_regrant: got %b, required 0000", bus.gnt); end
        repeat (2) @(negedge clk);
        n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL single_drain: got %0d pending reads, required 0", sb.size()); end
    endtask

    task automatic test_round_robin();
        pulse_reset();
        for (int k = 0; k < 4; k++) set_core(k, 1'b1, 1'b0, 8'(8'h20 + k), 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) sb.push_back('{4'(1 << (i % 4)), pat(8'(8'h20 + i % 4))});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.gnt !== 4'(1 << (i % 4)) || mem_en !== 1'b1 || mem_addr !== 8'(8'h20 + i % 4)) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got gnt=%b en=%b addr=%h, required gnt=%b en=1 addr=%h",
                         i, bus.gnt, mem_en, mem_addr, 4'(1 << (i % 4)), 8'(8'h20 + i % 4));
            end
        end
        clear_all();
        @(negedge clk);
        n_checks++; if (bus.gnt !== 4'b0000 || mem_en !== 1'b0) begin n_fail++; $display("FAIL rr_idle: got gnt=%b en=%b, required 0000 0", bus.gnt, mem_en); end
        repeat (2) @(negedge clk);
        n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL rr_drain: got %0d pending reads, required 0", sb.size()); end
    endtask

    task automatic test_lone_requester();
        set_core(1, 1'b1, 1'b1, 8'h30, 8'hC3, 1'b0);
        for (int i = 0; i < 6; i++) begin
            logic       exp_en;
            logic [3:0] exp_gnt;
            exp_en  = (i % 2 == 0);
            exp_gnt = exp_en ? 4'b0010 : 4'b0000;
            @(negedge clk);
            n_checks++;
            if (mem_en !== exp_en || bus.gnt !== exp_gnt) begin
                n_fail++;
                $display("FAIL lone_cycle[%0d]: got en=%b gnt=%b, required en=%b gnt=%b", i, mem_en, bus.gnt, exp_en, exp_gnt);
            end
            if (exp_en) begin
                n_checks++;
                if (mem_we !== 1'b1 || mem_addr !== 8'h30 || mem_wdata !== 8'hC3) begin
                    n_fail++;
                    $display("FAIL lone_write[%0d]: got we=%b addr=%h wdata=%h, required we=1 addr=30 wdata=c3",
                             i, mem_we, mem_addr, mem_wdata);
                end
            end
        end
        clear_all();
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL lone_idle: got en=%b, required 0", mem_en); end
    endtask

    task automatic test_withdraw();
        pulse_reset();
        set_core(0, 1'b1, 1'b0, 8'h40, 8'h00, 1'b0);
        set_core(1, 1'b1, 1'b0, 8'h41, 8'h00, 1'b0);
        set_core(3, 1'b1, 1'b1, 8'h43, 8'hEE, 1'b0);
        sb.push_back('{4'b0001, pat(8'h40)});
        sb.push_back('{4'b0010, pat(8'h41)});
        @(negedge clk);
        n_checks++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL withdraw_gnt0: got %b, required 0001", bus.gnt); end
        set_core(0, 1'b0, 1'b0, 8'h40, 8'h00, 1'b0);
        set_core(3, 1'b0, 1'b0, 8'h43, 8'h00, 1'b0);
        @(negedge clk);
        n_checks++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL withdraw_gnt1: got %b, required 0010", bus.gnt); end
        set_core(1, 1'b0, 1'b0, 8'h41, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.gnt !== 4'b0000 || mem_en !== 1'b0) begin
                n_fail++;
                $display("FAIL withdraw_idle[%0d]: got gnt=%b en=%b, required 0000 0", i, bus.gnt, mem_en);
            end
        end
        n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL withdraw_drain: got %0d pending reads, required 0", sb.size()); end
    endtask

    task automatic test_reset_mid_access();
        set_core(2, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
        @(negedge clk);
        n_checks++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL midrst_gnt: got %b, required 0100", bus.gnt); end
        reset = 1'b1;
        clear_all();
        @(negedge clk);
        n_checks++;
        if (bus.rvalid !== 4'b0 || bus.gnt !== 4'b0 || bus.rdata !== 8'h00 || mem_en !== 1'b0 ||
            mem_we !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_outputs: got rvalid=%b gnt=%b rdata=%h en=%b we=%b addr=%h wdata=%h, required all zero",
                     bus.rvalid, bus.gnt, bus.rdata, mem_en, mem_we, mem_addr, mem_wdata);
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) set_core(k, 1'b1, 1'b0, 8'(8'h60 + k), 8'h00, 1'b0);
        sb.push_back('{4'b0001, pat(8'h60)});
        @(negedge clk);
        n_checks++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL midrst_ptr: got %b, required 0001", bus.gnt); end
        clear_all();
        repeat (3) @(negedge clk);
        n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL midrst_drain: got %0d pending reads, required 0", sb.size()); end
    endtask

    task automatic test_lock();
        pulse_reset();
        set_core(0, 1'b1, 1'b0, 8'h50, 8'h00, 1'b1);
        for (int k = 1; k < 4; k++) set_core(k, 1'b1, 1'b0, 8'(8'h50 + k), 8'h00, 1'b0);
        for (int i = 0; i < 9; i++) begin
            int ec;
`ifdef SHARED_MEM_ARB_LOCK_EN
            ec = (i < 8) ? 0 : 1;
`else
            ec = i % 4;
`endif
            sb.push_back('{4'(1 << ec), pat(8'(8'h50 + ec))});
            @(negedge clk);
            n_checks++;
            if (bus.gnt !== 4'(1 << ec)) begin
                n_fail++;
                $display("FAIL lock_grant[%0d]: got %b, required %b", i, bus.gnt, 4'(1 << ec));
            end
        end
        clear_all();
        repeat (3) @(negedge clk);
        n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL lock_drain: got %0d pending reads, required 0", sb.size()); end
    endtask

    task automatic test_readback();
        logic [7:0] addrs [3];
        logic [7:0] datas [3];
        addrs = '{8'h30, 8'h43, 8'h10};
        datas = '{8'hC3, pat(8'h43), 8'h5A};
        for (int i = 0; i < 3; i++) begin
            bit got;
            got = 1'b0;
            set_core(2, 1'b1, 1'b0, addrs[i], 8'h00, 1'b0);
            sb.push_back('{4'b0100, datas[i]});
            for (int t = 0; t < 8 && !got; t++) begin
                @(negedge clk);
                got = (bus.gnt[2] === 1'b1);
            end
            n_checks++;
            if (!got) begin n_fail++; $display("FAIL readback_timeout[%0d]: got no gnt, required gnt[2]", i); end
            set_core(2, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
            repeat (2) @(negedge clk);
        end
        n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL readback_drain: got %0d pending reads, required 0", sb.size()); end
    endtask

    initial begin
        clear_all();
        test_reset();
        test_single_read();
        test_round_robin();
        test_lone_requester();
        test_withdraw();
        test_reset_mid_access();
        test_lock();
        test_readback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no completion, required finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
